// File: rtl/phase_arbiter_if.sv
// Lane request/lamp bundle between the demand sources and the phase arbiter.
interface phase_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] request;
  logic [N-1:0] green;
  logic [N-1:0] amber;
  logic [N-1:0] red;
  logic         busy;

  modport master (output request, input green, amber, red, busy);
  modport slave  (input request, output green, amber, red, busy);
endinterface

// File: rtl/phase_arbiter.sv
// Conflict-aware right-of-way scheduler: per-lane green/amber/clear sequencing
// with round-robin grants among conflicting lanes and min/max green timing.
module phase_arbiter #(
  parameter int               N         = 4,
  parameter logic [N*N-1:0]   CONFLICT  = 16'h4916,
  parameter int               MIN_GREEN = 8,
  parameter int               MAX_GREEN = 32,
  parameter int               AMBER     = 3,
  parameter int               CLEAR     = 2,
  parameter int               CW        = 6
) (
  input  logic           clock,
  input  logic           reset,
  phase_arbiter_if.slave lanes
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_AMBER, S_CLEAR} lane_state_t;

  lane_state_t   state_reg  [N];
  lane_state_t   state_next [N];
  logic [CW-1:0] timer_reg  [N];
  logic [CW-1:0] timer_next [N];
  logic [PW-1:0] pointer_reg, pointer_next;
  logic [N-1:0]  green_reg, amber_reg, red_reg;
  logic          busy_reg;

  logic [N-1:0]  conflict_row [N];
  logic [N-1:0]  occupied, waiter, granted;
  logic [N-1:0]  green_next, amber_next, red_next, occupied_next;
  logic          violation;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      // Diagonal masked so a lane never blocks itself.
      assign conflict_row[gi]  = CONFLICT[gi*N +: N] & ~(N'(1) << gi);
      assign occupied[gi]      = (state_reg[gi] != S_IDLE);
      assign waiter[gi]        = lanes.request[gi] && (state_reg[gi] == S_IDLE);
      assign green_next[gi]    = (state_next[gi] == S_GREEN);
      assign amber_next[gi]    = (state_next[gi] == S_AMBER);
      assign red_next[gi]      = (state_next[gi] == S_IDLE) || (state_next[gi] == S_CLEAR);
      assign occupied_next[gi] = (state_next[gi] != S_IDLE);
    end
  endgenerate

  // Round-robin scan from the pointer; earlier grants in the scan block later conflicting lanes.
  always_comb begin
    int idx;
    granted      = '0;
    pointer_next = pointer_reg;
    idx          = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer_reg) + k) % N;
      if (waiter[idx] && ((conflict_row[idx] & (occupied | granted)) == '0)) begin
        granted[idx] = 1'b1;
        pointer_next = PW'((idx + 1) % N);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_next[i] = state_reg[i];
      timer_next[i] = timer_reg[i];
      case (state_reg[i])
        S_IDLE: begin
          if (granted[i]) begin
            state_next[i] = S_GREEN;
            timer_next[i] = CW'(1);
          end
        end
        S_GREEN: begin
          if ((timer_reg[i] >= CW'(MIN_GREEN) && !lanes.request[i]) ||
              (timer_reg[i] >= CW'(MAX_GREEN) && (conflict_row[i] & waiter) != '0)) begin
            state_next[i] = S_AMBER;
            timer_next[i] = '0;
          end else if (timer_reg[i] < CW'(MAX_GREEN)) begin
            timer_next[i] = timer_reg[i] + CW'(1);
          end
        end
        S_AMBER: begin
          if (timer_reg[i] == CW'(AMBER - 1)) begin
            state_next[i] = S_CLEAR;
            timer_next[i] = '0;
          end else begin
            timer_next[i] = timer_reg[i] + CW'(1);
          end
        end
        S_CLEAR: begin
          if (timer_reg[i] == CW'(CLEAR - 1)) begin
            state_next[i] = S_IDLE;
            timer_next[i] = '0;
          end else begin
            timer_next[i] = timer_reg[i] + CW'(1);
          end
        end
        default: begin
          state_next[i] = S_IDLE;
          timer_next[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_reg[i] <= S_IDLE;
        timer_reg[i] <= '0;
      end
      pointer_reg <= '0;
      green_reg   <= '0;
      amber_reg   <= '0;
      red_reg     <= '1;
      busy_reg    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_reg[i] <= state_next[i];
        timer_reg[i] <= timer_next[i];
      end
      pointer_reg <= pointer_next;
      green_reg   <= green_next;
      amber_reg   <= amber_next;
      red_reg     <= red_next;
      busy_reg    <= |occupied_next;
    end
  end

  assign lanes.green = green_reg;
  assign lanes.amber = amber_reg;
  assign lanes.red   = red_reg;
  assign lanes.busy  = busy_reg;

  // Two conflicting lanes must never be out of IDLE together.
  always_comb begin
    violation = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (occupied[i] && ((conflict_row[i] & occupied) != '0)) violation = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!violation);
  end
endmodule
